// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and helpers for the fetch front end. Contains
//               RV32 opcode constants, the 2-bit branch-history counter with
//               saturating update functions, the instruction-queue entry,
//               the fetch FSM state type and the B/J immediate extractors.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Weakly-not-taken start point for every history counter.
  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef logic [1:0] bht_ctr_t;

  function automatic bht_ctr_t ctr_inc(input bht_ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic bht_ctr_t ctr_dec(input bht_ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] alt;
  } iq_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_JSTALL = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_bht.sv
`default_nettype none
// ============================================================================
// Module      : fetch_bht
// Description : Branch history table of 2-bit saturating counters with one
//               combinational read port and one training port.
// Ports       : clk_i, rst_i (sync, active low), rdy_i (global enable)
//               rd_idx_i / rd_ctr_o      : lookup
//               upd_i, upd_idx_i, upd_taken_i : training from commit
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_bht #(
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rdy_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);
  import fetch_pkg::*;

  localparam int ENTRIES = 2 ** IDX_W;

  bht_ctr_t tbl_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= BHT_INIT;
      end
    end else if (rdy_i && upd_i) begin
      tbl_q[upd_idx_i] <= upd_taken_i ? ctr_inc(tbl_q[upd_idx_i])
                                      : ctr_dec(tbl_q[upd_idx_i]);
    end
  end

  // Read is from the registered array, so a same-cycle update is not seen.
  assign rd_ctr_o = tbl_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/fetch_unit_bp.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_bp
// Description : Instruction fetch front end. Holds the PC, issues one ICache
//               request at a time, predecodes returned words (BHT-predicted
//               branches, JAL, JALR stall, AUIPC) and buffers them in a
//               circular instruction queue towards Issue.
// Ports       : clk_i, rst_i (sync, active low), rdy_i (global enable)
//               ic_*   : ICache request / response
//               is_*   : queue head towards Issue
//               alu_*  : JALR target resolution
//               rob_*  : flush/redirect, branch training, full back-pressure
//               lsb_full_i : back-pressure
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit_bp #(
  parameter int          BHT_IDX_W  = 8,
  parameter int          IQ_DEPTH_W = 3,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rdy_i,
  output logic        ic_req_o,
  output logic [31:0] ic_pc_o,
  input  logic        ic_valid_i,
  input  logic [31:0] ic_ins_i,
  output logic        is_valid_o,
  input  logic        is_ready_i,
  output logic [31:0] is_ins_o,
  output logic [31:0] is_pc_o,
  output logic        is_pred_taken_o,
  output logic [31:0] is_alt_pc_o,
  input  logic        alu_jalr_valid_i,
  input  logic [31:0] alu_jalr_pc_i,
  input  logic        rob_flush_i,
  input  logic [31:0] rob_flush_pc_i,
  input  logic        rob_br_upd_i,
  input  logic [31:0] rob_br_pc_i,
  input  logic        rob_br_taken_i,
  input  logic        rob_full_i,
  input  logic        lsb_full_i
);
  import fetch_pkg::*;

  localparam int                    DEPTH   = 2 ** IQ_DEPTH_W;
  localparam logic [IQ_DEPTH_W+1:0] DEPTH_C = (IQ_DEPTH_W + 2)'(DEPTH);

  fetch_state_e          state_q;
  logic [31:0]           pc_q;
  logic                  drop_q;
  logic                  ic_req_q;
  logic [31:0]           ic_pc_q;
  iq_entry_t             iq_q [DEPTH];
  logic [IQ_DEPTH_W-1:0] head_q;
  logic [IQ_DEPTH_W-1:0] tail_q;
  logic [IQ_DEPTH_W:0]   count_q;

  logic [1:0]  bht_ctr;
  iq_entry_t   entry_d;
  logic [31:0] next_pc_d;
  logic        is_jalr;
  logic        can_req;
  logic        push;
  logic        pop;
  iq_entry_t   head;

  fetch_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rdy_i       (rdy_i),
    .rd_idx_i    (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr_o    (bht_ctr),
    .upd_i       (rob_br_upd_i),
    .upd_idx_i   (rob_br_pc_i[BHT_IDX_W+1:2]),
    .upd_taken_i (rob_br_taken_i)
  );

  // Only the index bits of the training PC matter.
  logic unused_br_pc;
  assign unused_br_pc = ^{rob_br_pc_i[31:BHT_IDX_W+2], rob_br_pc_i[1:0]};

  // Predecode of the returning word; pc_q is the address it was fetched from.
  always_comb begin
    next_pc_d     = pc_q + 32'd4;
    is_jalr       = 1'b0;
    entry_d.ins   = ic_ins_i;
    entry_d.pc    = pc_q;
    entry_d.taken = 1'b0;
    entry_d.alt   = pc_q + 32'd4;
    case (ic_ins_i[6:0])
      OPC_BRANCH: begin
        entry_d.taken = bht_ctr[1];
        if (bht_ctr[1]) begin
          next_pc_d = pc_q + imm_b(ic_ins_i);
        end else begin
          entry_d.alt = pc_q + imm_b(ic_ins_i);
        end
      end
      OPC_JAL: begin
        entry_d.taken = 1'b1;
        next_pc_d     = pc_q + imm_j(ic_ins_i);
      end
      OPC_JALR: begin
        // Target unknown until the ALU resolves it; pc is replaced then.
        is_jalr   = 1'b1;
        next_pc_d = pc_q;
      end
      OPC_AUIPC: begin
        entry_d.alt = pc_q;
      end
      default: ;
    endcase
  end

  // Request only if a slot is guaranteed for the word once it returns.
  assign can_req = ({1'b0, count_q} + 1'b1) <= DEPTH_C;
  assign push    = (state_q == ST_WAIT) && ic_valid_i && !drop_q;
  assign pop     = is_valid_o && is_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      ic_req_q <= 1'b0;
      ic_pc_q  <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else if (rdy_i) begin
      if (rob_flush_i) begin
        pc_q    <= rob_flush_pc_i;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        if ((state_q == ST_WAIT) && !ic_valid_i) begin
          // Request still outstanding: keep it up and discard its response.
          drop_q <= 1'b1;
        end else begin
          // Either no request, or its response arrives now and is discarded.
          state_q  <= ST_IDLE;
          drop_q   <= 1'b0;
          ic_req_q <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (can_req && !rob_full_i && !lsb_full_i) begin
              ic_req_q <= 1'b1;
              ic_pc_q  <= pc_q;
              state_q  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (ic_valid_i) begin
              ic_req_q <= 1'b0;
              if (drop_q) begin
                drop_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                pc_q    <= next_pc_d;
                state_q <= is_jalr ? ST_JSTALL : ST_IDLE;
              end
            end
          end
          ST_JSTALL: begin
            if (alu_jalr_valid_i) begin
              pc_q    <= alu_jalr_pc_i;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase

        if (push) begin
          iq_q[tail_q] <= entry_d;
          tail_q       <= tail_q + 1'b1;
        end
        if (pop) begin
          head_q <= head_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign head            = iq_q[head_q];
  assign is_valid_o      = (count_q != '0);
  assign is_ins_o        = head.ins;
  assign is_pc_o         = head.pc;
  assign is_pred_taken_o = head.taken;
  assign is_alt_pc_o     = head.alt;
  assign ic_req_o        = ic_req_q;
  assign ic_pc_o         = ic_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_bp.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit_bp
// Description : Self-checking bench for fetch_unit_bp. A behavioural model
//               (expected fetch PC, queue of expected entries, BHT counters)
//               is advanced on every rising edge from the observed inputs and
//               compared against the DUT on every falling edge. Directed
//               phases walk reset, sequential fetch, branch/jal/jalr/auipc
//               predecode, BHT training, flush with drop, back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit_bp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy;
  logic        ic_req, ic_valid;
  logic [31:0] ic_pc, ic_ins;
  logic        is_valid, is_ready, is_pred_taken;
  logic [31:0] is_ins, is_pc, is_alt_pc;
  logic        alu_jalr_valid, rob_flush, rob_br_upd, rob_br_taken, rob_full, lsb_full;
  logic [31:0] alu_jalr_pc, rob_flush_pc, rob_br_pc;

  fetch_unit_bp #(
    .BHT_IDX_W  (8),
    .IQ_DEPTH_W (3),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .rdy_i            (rdy),
    .ic_req_o         (ic_req),
    .ic_pc_o          (ic_pc),
    .ic_valid_i       (ic_valid),
    .ic_ins_i         (ic_ins),
    .is_valid_o       (is_valid),
    .is_ready_i       (is_ready),
    .is_ins_o         (is_ins),
    .is_pc_o          (is_pc),
    .is_pred_taken_o  (is_pred_taken),
    .is_alt_pc_o      (is_alt_pc),
    .alu_jalr_valid_i (alu_jalr_valid),
    .alu_jalr_pc_i    (alu_jalr_pc),
    .rob_flush_i      (rob_flush),
    .rob_flush_pc_i   (rob_flush_pc),
    .rob_br_upd_i     (rob_br_upd),
    .rob_br_pc_i      (rob_br_pc),
    .rob_br_taken_i   (rob_br_taken),
    .rob_full_i       (rob_full),
    .lsb_full_i       (lsb_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00000463;  // beq x0,x0,+8
      32'h20:  return 32'h008000EF;  // jal x1,+8
      32'h30:  return 32'h00008067;  // jalr x0,0(x1)
      32'h108: return 32'h00000517;  // auipc a0,0
      default: return 32'h00000013;  // nop
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] alt;
  } ent_t;

  ent_t        m_q[$];
  ent_t        popped[$];
  logic [31:0] m_pc;
  bit          m_drop, m_jstall;
  int          m_bht[256];
  bit          chk_en = 0;

  function automatic ent_t predict(input logic [31:0] pc, input logic [31:0] ins,
                                   output logic [31:0] nxt, output bit jalr);
    ent_t        e;
    logic [31:0] ib, ij;
    int          idx;
    ib    = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij    = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    idx   = int'((pc >> 2) % 256);
    e.ins = ins;
    e.pc  = pc;
    jalr  = 0;
    if (ins[6:0] == 7'h63) begin
      e.taken = (m_bht[idx] >= 2);
      nxt     = e.taken ? pc + ib : pc + 4;
      e.alt   = e.taken ? pc + 4  : pc + ib;
    end else if (ins[6:0] == 7'h6F) begin
      e.taken = 1; nxt = pc + ij; e.alt = pc + 4;
    end else if (ins[6:0] == 7'h67) begin
      e.taken = 0; nxt = pc; e.alt = pc + 4; jalr = 1;
    end else if (ins[6:0] == 7'h17) begin
      e.taken = 0; nxt = pc + 4; e.alt = pc;
    end else begin
      e.taken = 0; nxt = pc + 4; e.alt = pc + 4;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc     = 32'h0;
      m_drop   = 0;
      m_jstall = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
    end else if (rdy) begin
      bit          do_pop;
      bit          jl;
      logic [31:0] nx;
      ent_t        e;
      do_pop = (m_q.size() != 0) && is_ready;
      if (rob_flush) begin
        m_q.delete();
        m_pc     = rob_flush_pc;
        m_jstall = 0;
        if (ic_valid)    m_drop = 0;
        else if (ic_req) m_drop = 1;
      end else begin
        if (m_jstall && alu_jalr_valid) begin
          m_pc     = alu_jalr_pc;
          m_jstall = 0;
        end
        if (do_pop) popped.push_back(m_q.pop_front());
        if (ic_valid) begin
          if (m_drop) m_drop = 0;
          else begin
            e = predict(m_pc, ic_ins, nx, jl);
            m_q.push_back(e);
            m_pc = nx;
            if (jl) m_jstall = 1;
          end
        end
      end
      if (rob_br_upd) begin
        int k;
        k = int'((rob_br_pc >> 2) % 256);
        if (rob_br_taken) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
        else              m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check1("is_valid", is_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check32("is_pc", is_pc, m_q[0].pc);
        check32("is_ins", is_ins, m_q[0].ins);
        check1("is_pred_taken", is_pred_taken, m_q[0].taken);
        check32("is_alt_pc", is_alt_pc, m_q[0].alt);
      end
      if (ic_req && !m_drop) check32("ic_pc", ic_pc, m_pc);
      if (m_jstall) check1("jstall_no_req", ic_req, 1'b0);
    end
  end

  // ---------------- ICache responder ----------------
  bit icache_en = 1;
  int lat = 0;
  always @(negedge clk) begin
    if (!rst_n || !ic_req) begin
      ic_valid = 0;
      lat      = 0;
    end else if (icache_en) begin
      if (lat >= 1) begin
        ic_valid = 1;
        ic_ins   = mem(ic_pc);
      end else begin
        lat++;
      end
    end else begin
      ic_valid = 0;
    end
  end

  // ---------------- helpers ----------------
  function automatic int find_pc(input logic [31:0] pc);
    foreach (popped[i]) if (popped[i].pc == pc) return i;
    return -1;
  endfunction

  task automatic wait_pop(input logic [31:0] pc, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (find_pc(pc) >= 0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_pop: pc %h not delivered within %0d cycles", pc, budget);
  endtask

  task automatic wait_req(input logic [31:0] pc, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ic_req && ic_pc == pc) begin
        check32("req_addr", ic_pc, pc);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_req: request for %h not seen within %0d cycles", pc, budget);
  endtask

  task automatic check_entry(input string name, input logic [31:0] pc,
                             input logic taken, input logic [31:0] alt);
    int i;
    i = find_pc(pc);
    n_checks++;
    if (i < 0) begin
      n_fail++;
      $display("FAIL %s: entry for pc %h missing, expected present", name, pc);
    end else begin
      n_checks--;
      check1({name, "_taken"}, popped[i].taken, taken);
      check32({name, "_alt"}, popped[i].alt, alt);
    end
  endtask

  task automatic check_seq(input string name, input logic [31:0] exp[$]);
    foreach (exp[i]) begin
      if (i < popped.size()) check32(name, popped[i].pc, exp[i]);
      else                   check32(name, 32'hxxxxxxxx, exp[i]);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] seq[$];
    rst_n = 0; rdy = 1; is_ready = 0;
    alu_jalr_valid = 0; alu_jalr_pc = 0;
    rob_flush = 0; rob_flush_pc = 0;
    rob_br_upd = 0; rob_br_pc = 0; rob_br_taken = 0;
    rob_full = 0; lsb_full = 0;
    ic_valid = 0; ic_ins = 0;
    repeat (3) @(negedge clk);
    check1("rst_ic_req", ic_req, 1'b0);
    check1("rst_is_valid", is_valid, 1'b0);
    check32("rst_ic_pc", ic_pc, 32'h0);

    rst_n = 1; is_ready = 1; chk_en = 1;
    // Stray JALR resolution outside the stall must be ignored.
    repeat (2) @(negedge clk);
    alu_jalr_valid = 1; alu_jalr_pc = 32'h500;
    @(negedge clk);
    alu_jalr_valid = 0;

    // Sequential fetch through beq, jal, then jalr stall.
    wait_pop(32'h30, 300);
    repeat (5) begin
      @(negedge clk);
      check1("jalr_stall_req", ic_req, 1'b0);
    end
    alu_jalr_valid = 1; alu_jalr_pc = 32'h100;
    @(negedge clk);
    alu_jalr_valid = 0;
    wait_pop(32'h10c, 300);
    seq = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14, 32'h18, 32'h1c,
            32'h20, 32'h28, 32'h2c, 32'h30, 32'h100, 32'h104, 32'h108, 32'h10c};
    check_seq("seq_pc", seq);
    check_entry("nop0", 32'h0, 1'b0, 32'h4);
    check_entry("beq_untrained", 32'h10, 1'b0, 32'h18);
    check_entry("jal", 32'h20, 1'b1, 32'h24);
    check_entry("jalr", 32'h30, 1'b0, 32'h34);
    check_entry("auipc", 32'h108, 1'b0, 32'h108);

    // Train the beq twice toward taken, then refetch it via a flush.
    rob_br_upd = 1; rob_br_pc = 32'h10; rob_br_taken = 1;
    repeat (2) @(negedge clk);
    rob_br_upd = 0;
    icache_en = 0;
    repeat (3) @(negedge clk);
    popped.delete();
    rob_flush = 1; rob_flush_pc = 32'h10;
    @(negedge clk);
    rob_flush = 0; icache_en = 1;
    wait_pop(32'h30, 300);
    seq = '{32'h10, 32'h18, 32'h1c, 32'h20, 32'h28, 32'h2c, 32'h30};
    check_seq("trained_pc", seq);
    check_entry("beq_trained", 32'h10, 1'b1, 32'h14);

    // Flush while the 0x40 request is outstanding.
    icache_en = 0;
    alu_jalr_valid = 1; alu_jalr_pc = 32'h40;
    @(negedge clk);
    alu_jalr_valid = 0;
    wait_req(32'h40, 20);
    popped.delete();
    rob_flush = 1; rob_flush_pc = 32'h200;
    @(negedge clk);
    rob_flush = 0;
    check1("flush_is_valid", is_valid, 1'b0);
    icache_en = 1;
    wait_req(32'h200, 40);
    wait_pop(32'h20c, 300);
    check32("flush_first_pc", popped.size() > 0 ? popped[0].pc : 32'hxxxxxxxx, 32'h200);
    check32("dropped_absent", 32'(find_pc(32'h40)), 32'hffffffff);

    // Back-pressure: queue fills to exactly its depth, then fetch stops.
    is_ready = 0;
    repeat (40) @(negedge clk);
    check1("full_is_valid", is_valid, 1'b1);
    check32("full_occupancy", 32'(m_q.size()), 32'd8);
    check1("full_no_req", ic_req, 1'b0);
    // Global enable low: nothing moves even though Issue is ready.
    rdy = 0; is_ready = 1;
    repeat (3) @(negedge clk);
    check1("rdy0_is_valid", is_valid, 1'b1);
    check32("rdy0_occupancy", 32'(m_q.size()), 32'd8);
    rdy = 1; rob_full = 1;
    repeat (30) @(negedge clk);
    check1("robfull_no_req", ic_req, 1'b0);
    check1("robfull_drained", is_valid, 1'b0);
    rob_full = 0;
    wait_pop(32'h200 + 32'd80, 400);
    seq.delete();
    for (int i = 0; i <= 20; i++) seq.push_back(32'h200 + 32'(4 * i));
    check_seq("resume_pc", seq);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit_bp.md
Name: fetch_unit_bp

Overview:
Parametrised instruction-fetch front end for the Tomasulo core. It sits between ICache and Issue. It holds the PC and predecodes each returned word, predicting branches with a trainable 2-bit BHT. Fetched words are buffered in an instruction queue so Issue back-pressure no longer stalls ICache traffic. It stalls on JALR until the ALU resolves the target, and recovers on ROB mispredict flush.

Parameters:
BHT_IDX_W, 8, BHT has 2^BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2]
IQ_DEPTH_W, 3, instruction queue holds 2^IQ_DEPTH_W entries
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
rdy  in  1  global enable; low freezes all state
ic_req  out  1  fetch request to ICache
ic_pc  out  32  fetch address
ic_valid  in  1  ICache returns word for ic_pc
ic_ins  in  32  returned instruction
is_valid  out  1  queue head valid
is_ready  in  1  Issue accepts head
is_ins  out  32  head instruction
is_pc  out  32  head PC
is_pred_taken  out  1  branch predicted taken
is_alt_pc  out  32  other path / link / auipc base (see Behaviour)
alu_jalr_valid  in  1  JALR target resolved
alu_jalr_pc  in  32  JALR target
rob_flush  in  1  mispredict; redirect
rob_flush_pc  in  32  redirect target
rob_br_upd  in  1  committed branch outcome
rob_br_pc  in  32  PC of that branch
rob_br_taken  in  1  actual direction
rob_full  in  1  blocks new requests
lsb_full  in  1  blocks new requests

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC; state=IDLE; queue empty; drop=0.
  - ic_req=0, ic_pc=RESET_PC, is_valid=0.
  - Every BHT entry is set to 2'b01.
- rdy==0: no register or BHT changes; outputs hold.
- FSM IDLE:
  - Raise ic_req with ic_pc=pc when (count + 1) <= 2^IQ_DEPTH_W, !rob_full and !lsb_full; go to WAIT.
- FSM WAIT:
  - ic_req and ic_pc stay stable until ic_valid.
  - On ic_valid with drop==0: predecode, push one entry, update pc, then go to IDLE, or to JSTALL if the word is JALR.
  - On ic_valid with drop==1: discard the word, clear drop, go to IDLE.
- FSM JSTALL:
  - ic_req=0.
  - alu_jalr_valid: pc=alu_jalr_pc, go to IDLE.
  - alu_jalr_valid in any other state is ignored.
- Predecode (imm sign-extended, opcode ins[6:0]):
  - BRANCH (1100011): taken=BHT[idx][1].
    - Taken: next=pc+imm_b, alt=pc+4.
    - Not taken: next=pc+4, alt=pc+imm_b.
  - JAL (1101111): next=pc+imm_j, alt=pc+4, taken=1.
  - JALR (1100111): alt=pc+4, taken=0, stall.
  - AUIPC (0010111): next=pc+4, alt=pc.
  - Others: next=pc+4, alt=pc+4, taken=0.
  - All PC arithmetic is modulo 2^32.
- Queue:
  - Circular FIFO of {ins, pc, taken, alt}.
  - Head is presented combinationally; pop when is_valid && is_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - The request rule guarantees a push never overflows.
- rob_flush (highest priority over everything except reset):
  - Queue emptied, is_valid=0 next cycle; pc=rob_flush_pc.
  - From IDLE or JSTALL: go to IDLE.
  - From WAIT: stay in WAIT with drop=1 (the outstanding word is discarded).
  - A simultaneous ic_valid in that cycle is also discarded. Drop is cleared only by the response of the request outstanding at flush time.
  - A same-cycle pop is void.
- BHT training:
  - On rob_br_upd, entry rob_br_pc[BHT_IDX_W+1:2] saturates toward 11 if taken, toward 00 if not.
  - A lookup of the same entry in the same cycle sees the pre-update value.
  - Flush does not clear the BHT.

Decomposition:
- Package fetch_pkg holds: opcode constants, the 2-bit counter type with saturating-increment/decrement functions, the queue entry struct, and immediate-extract functions.
- Sub-module fetch_bht: BHT array, synchronous-reset init, read port, and training port.

Test Plan:
- Reset, then ICache returns 32'h00000013 at each PC -> ic_pc 0,4,8,...; head is_pc=0, is_pred_taken=0, is_alt_pc=4.
- beq at 0x10 (32'h00000463):
  - Untrained -> next ic_pc 0x14, alt 0x18.
  - After two rob_br_upd taken for 0x10, refetch -> next ic_pc 0x18, is_pred_taken=1, alt 0x14.
- jal at 0x20 (32'h008000EF) -> next ic_pc 0x28, is_alt_pc 0x24.
- jalr at 0x30 (32'h00008067) -> ic_req stays 0 for 5 cycles; alu_jalr_valid with 0x100 -> next ic_pc 0x100.
- rob_flush to 0x200 while the 0x40 request is outstanding -> 0x40 word never appears, queue empty, next ic_pc 0x200.
- is_ready=0 with depth 8 -> exactly 8 entries queued, ic_req then 0. rob_full=1 also blocks new requests. Releasing both resumes fetch with in-order PCs.
